isi_channel_ocm_filter: RTL and testbench

Symbol-rate ISI (inter-symbol-interference) channel model for the SERDES simulation datapath. It first loads its pulse-response taps from an external 64-bit on-chip memory port, one word per cycle, using the location/mem_data interface. It then convolves the incoming symbol stream with those taps and drives the distorted stream downstream. The on-chip RAM and its address counter are external to this block.

---
 rtl/isi_channel_ocm_filter_if.sv | 24 ++
 rtl/isi_channel_ocm_filter.sv | 95 +++++++++
 tb/tb_isi_channel_ocm_filter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/isi_channel_ocm_filter_if.sv
// Bus bundle for isi_channel_ocm_filter: symbol stream in/out plus the
// pulse-response memory load port.
interface isi_channel_ocm_filter_if #(
    parameter int SIGNAL_RESOLUTION = 8
);
    logic signed [SIGNAL_RESOLUTION-1:0] signal_in;
    logic                                signal_in_valid;
    logic signed [SIGNAL_RESOLUTION-1:0] signal_out;
    logic                                signal_out_valid;
    logic                                load_mem;
    logic                                done_wait;
    logic [7:0]                          location;
    logic [63:0]                         mem_data;

    modport master (
        output signal_in, signal_in_valid, load_mem, location, mem_data,
        input  signal_out, signal_out_valid, done_wait
    );

    modport slave (
        input  signal_in, signal_in_valid, load_mem, location, mem_data,
        output signal_out, signal_out_valid, done_wait
    );
endinterface

// File: rtl/isi_channel_ocm_filter.sv
// Symbol-rate ISI channel model: loads taps from a 64-bit memory image, then
// convolves the symbol stream with them. Define ISI_OCM_SATURATE_EN to clamp.
module isi_channel_ocm_filter #(
    parameter int PULSE_RESPONSE_LENGTH = 3,
    parameter int SIGNAL_RESOLUTION     = 8,
    parameter int SYMBOL_SEPERATION     = 56
) (
    input logic                    clk,
    input logic                    reset,
    isi_channel_ocm_filter_if.slave bus
);
    localparam int L         = PULSE_RESPONSE_LENGTH;
    localparam int W         = SIGNAL_RESOLUTION;
    localparam int HIST      = (L > 1) ? L - 1 : 1;
    localparam int ACC_W     = 2 * W + $clog2(L);
    localparam int LAST_WORD = ((L - 1) * SYMBOL_SEPERATION) / 8;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [W-1:0]     taps [L];
    logic signed [W-1:0]     hist [HIST];
    logic signed [W-1:0]     out_q;
    logic                    out_valid_q;
    logic                    done_q;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] shifted;
    logic signed [W-1:0]     result;
    logic                    loading;
    logic                    accept;

    assign loading = bus.load_mem && !done_q;
    assign accept  = bus.signal_in_valid && done_q;

    // Convolution over the pre-shift history, then scale back to Q1.(W-1).
    always_comb begin
        acc = ACC_W'(bus.signal_in) * ACC_W'(taps[0]);
        for (int k = 1; k < L; k++) begin
            acc = acc + ACC_W'(hist[k-1]) * ACC_W'(taps[k]);
        end
        shifted = acc >>> (W - 1);
`ifdef ISI_OCM_SATURATE_EN
        if (shifted > SAT_MAX) begin
            result = W'(SAT_MAX);
        end else if (shifted < SAT_MIN) begin
            result = W'(SAT_MIN);
        end else begin
            result = W'(shifted);
        end
`else
        result = W'(shifted);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < L; k++) begin
                taps[k] <= '0;
            end
            for (int k = 0; k < HIST; k++) begin
                hist[k] <= '0;
            end
            out_q       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // Several taps can share one word; every matching byte is captured.
            if (loading) begin
                for (int k = 0; k < L; k++) begin
                    for (int b = 0; b < 8; b++) begin
                        if (int'(bus.location) * 8 + b == k * SYMBOL_SEPERATION) begin
                            taps[k] <= W'($signed(bus.mem_data[8*b +: 8]));
                        end
                    end
                end
                if (int'(bus.location) == LAST_WORD) begin
                    done_q <= 1'b1;
                end
            end

            out_valid_q <= accept;
            if (accept) begin
                out_q   <= result;
                hist[0] <= bus.signal_in;
                for (int k = 1; k < HIST; k++) begin
                    hist[k] <= hist[k-1];
                end
            end
        end
    end

    assign bus.signal_out       = out_q;
    assign bus.signal_out_valid = out_valid_q;
    assign bus.done_wait        = done_q;
endmodule

// File: tb/tb_isi_channel_ocm_filter.sv
// Self-checking bench for isi_channel_ocm_filter: table vectors, corner
// sequences and a randomized stream against a convolution reference model.
module tb_isi_channel_ocm_filter;
    localparam int L         = 3;
    localparam int W         = 8;
    localparam int SEP       = 56;
    localparam int LAST_WORD = ((L - 1) * SEP) / 8;
    localparam int NBYTES    = 8 * (LAST_WORD + 1);

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    int   mtap [L];
    int   mhist[$];
    int   lastOut;
    logic [7:0] img [NBYTES];

    typedef struct {
        int sample;
        bit valid;
        bit expValid;
        int expOut;
    } vec_t;
    vec_t vecs [7];

    isi_channel_ocm_filter_if #(.SIGNAL_RESOLUTION(W)) bus ();

    isi_channel_ocm_filter #(
        .PULSE_RESPONSE_LENGTH(L),
        .SIGNAL_RESOLUTION(W),
        .SYMBOL_SEPERATION(SEP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int sample, input bit valid, input bit load,
                                 input int loc, input logic [63:0] data);
        bus.signal_in       = W'(sample);
        bus.signal_in_valid = valid;
        bus.load_mem        = load;
        bus.location        = 8'(loc);
        bus.mem_data        = data;
    endtask

    // Reference: direct convolution over the list of accepted samples.
    function automatic int modelStep(input int x);
        int acc;
        int q;
        acc = x * mtap[0];
        for (int k = 1; k < L; k++) begin
            if (k - 1 < mhist.size()) acc += mhist[k-1] * mtap[k];
        end
        mhist.push_front(x);
        if (mhist.size() > L - 1) void'(mhist.pop_back());
        q = acc >>> (W - 1);
`ifdef ISI_OCM_SATURATE_EN
        if (q > (1 << (W - 1)) - 1) q = (1 << (W - 1)) - 1;
        if (q < -(1 << (W - 1)))    q = -(1 << (W - 1));
`else
        q = ((q % (1 << W)) + (1 << W)) % (1 << W);
        if (q >= (1 << (W - 1))) q -= (1 << W);
`endif
        return q;
    endfunction

    task automatic resetDut();
        applyStimulus(0, 0, 0, 0, 64'd0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        mhist.delete();
        lastOut = 0;
    endtask

    task automatic loadTaps(input bit validDuringLoad, input bit gaps);
        logic [63:0] word;
        for (int i = 0; i < NBYTES; i++) img[i] = 8'($urandom_range(0, 255));
        for (int k = 0; k < L; k++) img[k * SEP] = 8'(mtap[k]);
        for (int loc = 0; loc <= LAST_WORD; loc++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                applyStimulus(0, 0, 0, loc, {$urandom, $urandom});
                tick();
                checkOutput("done_wait_gap", int'(bus.done_wait), 0);
            end
            for (int b = 0; b < 8; b++) word[8*b +: 8] = img[loc * 8 + b];
            applyStimulus($urandom_range(0, 255) - 128, validDuringLoad, 1, loc, word);
            tick();
            checkOutput("done_wait_load", int'(bus.done_wait), (loc == LAST_WORD) ? 1 : 0);
            checkOutput("out_valid_load", int'(bus.signal_out_valid), 0);
        end
        applyStimulus(0, 0, 0, 0, 64'd0);
    endtask

    task automatic streamSample(input string name, input int x, input bit v);
        applyStimulus(x, v, 0, 0, 64'd0);
        if (v) lastOut = modelStep(x);
        tick();
        checkOutput({name, "_valid"}, int'(bus.signal_out_valid), int'(v));
        checkOutput({name, "_out"}, int'(bus.signal_out), lastOut);
    endtask

    initial begin
        vecs[0] = '{100, 1'b1, 1'b1, 50};
        vecs[1] = '{0,   1'b1, 1'b1, 25};
        vecs[2] = '{0,   1'b1, 1'b1, 12};
        vecs[3] = '{0,   1'b1, 1'b1, 0};
        vecs[4] = '{100, 1'b1, 1'b1, 50};
        vecs[5] = '{77,  1'b0, 1'b0, 50};
        vecs[6] = '{0,   1'b1, 1'b1, 25};

        reset = 1'b1;
        resetDut();
        checkOutput("reset_done_wait", int'(bus.done_wait), 0);
        checkOutput("reset_out_valid", int'(bus.signal_out_valid), 0);
        checkOutput("reset_out", int'(bus.signal_out), 0);

        // Default taps, done_wait timing, then reset clears everything.
        mtap = '{64, 32, 16};
        loadTaps(1'b0, 1'b0);
        resetDut();
        checkOutput("reload_reset_done", int'(bus.done_wait), 0);
        checkOutput("reload_reset_out", int'(bus.signal_out), 0);

        // Samples offered during load must not be accepted or enter history.
        loadTaps(1'b1, 1'b1);
        applyStimulus(0, 0, 0, 0, 64'd0);
        tick();
        checkOutput("post_load_valid", int'(bus.signal_out_valid), 0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].sample, vecs[i].valid, 0, 0, 64'd0);
            if (vecs[i].valid) void'(modelStep(vecs[i].sample));
            tick();
            checkOutput($sformatf("vec%0d_valid", i), int'(bus.signal_out_valid), int'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d_out", i), int'(bus.signal_out), vecs[i].expOut);
        end
        lastOut = 25;

        // Loading after done_wait must leave taps frozen.
        applyStimulus(0, 0, 1, 0, 64'h7F7F_7F7F_7F7F_7F7F);
        tick();
        applyStimulus(0, 0, 1, 7, 64'h0101_0101_0101_0101);
        tick();
        streamSample("frozen0", 100, 1);
        streamSample("frozen1", 0, 1);
        streamSample("frozen2", 0, 1);
        checkOutput("frozen_const", int'(bus.signal_out), 12);

        // Reset mid-stream: no valid output until a reload completes.
        applyStimulus(50, 1, 0, 0, 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mhist.delete();
        lastOut = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(40, 1, 0, 0, 64'd0);
            tick();
            checkOutput("midreset_valid", int'(bus.signal_out_valid), 0);
            checkOutput("midreset_done", int'(bus.done_wait), 0);
        end

        // Full-scale taps: overflow behaviour and most-negative input.
        mtap = '{127, 127, 127};
        loadTaps(1'b0, 1'b0);
        streamSample("big0", 127, 1);
        streamSample("big1", 127, 1);
        streamSample("big2", 127, 1);
`ifdef ISI_OCM_SATURATE_EN
        checkOutput("big2_const", int'(bus.signal_out), 127);
`else
        checkOutput("big2_const", int'(bus.signal_out), 122);
`endif
        resetDut();
        loadTaps(1'b0, 1'b0);
        streamSample("neg0", -128, 1);
        checkOutput("neg0_const", int'(bus.signal_out), -127);

        // Randomized taps and stream.
        for (int round = 0; round < 3; round++) begin
            resetDut();
            for (int k = 0; k < L; k++) mtap[k] = $urandom_range(0, 255) - 128;
            loadTaps(1'(round), 1'b1);
            for (int i = 0; i < 150; i++) begin
                streamSample("rand", $urandom_range(0, 255) - 128, $urandom_range(0, 3) != 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
